// File: rtl/encodelow_seq.sv
// Registered 4-to-2 priority encoder for active-low strobes: synchronises each line,
// latches falling edges as pending events and hands them out one at a time over valid/ready.
`timescale 1ns/1ps
module encodelow_seq #(
  parameter int SYNC_STAGES = 2,
  parameter bit LOW_FIRST   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic s0,
  output logic s1,
  output logic valid,
  input  logic ready,
  output logic multi,
  output logic drop
);

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [3:0]             line_in;
  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [SYNC_STAGES-1:0] sync_d [4];
  logic [3:0]             synced;
  logic [3:0]             prev_q, prev_d;
  logic [3:0]             events;
  logic [3:0]             pending_q, pending_d;
  logic [3:0]             clear;
  logic [1:0]             sel;
  logic [1:0]             idx_q, idx_d;
  logic                   multi_q, multi_d;
  logic                   drop_q, drop_d;
  logic                   load;
  state_t                 state_q, state_d;

  assign line_in = {d3, d2, d1, d0};

  // Bit 0 of each chain takes the raw pin; the last bit is the synchronised view.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], line_in[i]};
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
    prev_d = synced;
    events = ~synced & prev_q;
  end

  always_comb begin
    sel = 2'd0;
    if (LOW_FIRST) begin
      for (int i = 3; i >= 0; i--) begin
        if (pending_q[i]) sel = 2'(i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pending_q[i]) sel = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    clear   = 4'b0000;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q != 4'b0000) load = 1'b1;
      end
      PRESENT: begin
        if (ready) begin
          if (pending_q != 4'b0000) load = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      clear   = 4'b0001 << sel;
      idx_d   = sel;
      multi_d = (pending_q & ~clear) != 4'b0000;
      state_d = PRESENT;
    end
    // A new event on the line being delivered re-arms it rather than counting as a loss.
    drop_d    = |(events & pending_q & ~clear);
    pending_d = (pending_q & ~clear) | events;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) sync_q[i] <= '1;
      prev_q    <= 4'b1111;
      pending_q <= 4'b0000;
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      multi_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) sync_q[i] <= sync_d[i];
      prev_q    <= prev_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      multi_q   <= multi_d;
      drop_q    <= drop_d;
    end
  end

  assign s0    = idx_q[0];
  assign s1    = idx_q[1];
  assign valid = (state_q == PRESENT);
  assign multi = multi_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_encodelow_seq.sv
// Bench for encodelow_seq: two instances (default, and 3-stage high-first) driven by the
// same lines, checked every cycle against an event-history model plus literal scenarios.
`timescale 1ns/1ps
module tb_encodelow_seq;

  localparam int S_A  = 2;
  localparam bit LF_A = 1'b1;
  localparam int S_B  = 3;
  localparam bit LF_B = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d0 = 1'b1, d1 = 1'b1, d2 = 1'b1, d3 = 1'b1;
  logic ready = 1'b0;

  logic a_s0, a_s1, a_valid, a_multi, a_drop;
  logic b_s0, b_s1, b_valid, b_multi, b_drop;

  int num_compared   = 0;
  int num_mismatched = 0;

  encodelow_seq #(.SYNC_STAGES(S_A), .LOW_FIRST(LF_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .s0(a_s0), .s1(a_s1), .valid(a_valid), .ready(ready), .multi(a_multi), .drop(a_drop)
  );

  encodelow_seq #(.SYNC_STAGES(S_B), .LOW_FIRST(LF_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .s0(b_s0), .s1(b_s1), .valid(b_valid), .ready(ready), .multi(b_multi), .drop(b_drop)
  );

  always #5 clk = ~clk;

  // Model: hist[line][k] is the pin value sampled k+1 edges ago. A line with S sync
  // stages shows an event when the sample S edges ago is low and the one before it high.
  bit         hist [4][5];
  logic [3:0] m_pend  [2];
  logic       m_valid [2];
  logic [1:0] m_s     [2];
  logic       m_multi [2];
  logic       m_drop  [2];
  logic [3:0] m_ev;
  logic [3:0] m_clr;
  int         m_st;
  bit         m_lf;
  int         m_pick;

  function automatic int pickIndex(input logic [3:0] p, input bit lf);
    if (lf) begin
      for (int i = 0; i < 4; i++) if (p[i]) return i;
    end else begin
      for (int i = 3; i >= 0; i--) if (p[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 5; k++) hist[i][k] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = 4'b0; m_valid[m] = 1'b0; m_s[m] = 2'd0;
        m_multi[m] = 1'b0; m_drop[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        m_st = (m == 0) ? S_A : S_B;
        m_lf = (m == 0) ? LF_A : LF_B;
        for (int i = 0; i < 4; i++) m_ev[i] = !hist[i][m_st-1] && hist[i][m_st];
        m_clr = 4'b0;
        if (m_pend[m] != 4'b0 && (!m_valid[m] || ready)) begin
          m_pick      = pickIndex(m_pend[m], m_lf);
          m_clr[m_pick] = 1'b1;
          m_s[m]      = 2'(m_pick);
          m_multi[m]  = (m_pend[m] & ~m_clr) != 4'b0;
          m_valid[m]  = 1'b1;
        end else if (m_valid[m] && ready) begin
          m_valid[m] = 1'b0;
        end
        m_drop[m] = |(m_ev & m_pend[m] & ~m_clr);
        m_pend[m] = (m_pend[m] & ~m_clr) | m_ev;
      end
      for (int i = 0; i < 4; i++) begin
        for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
      end
      hist[0][0] = d0; hist[1][0] = d1; hist[2][0] = d2; hist[3][0] = d3;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("A.valid", {3'b0, a_valid}, {3'b0, m_valid[0]});
      checkOutput("A.s",     {2'b0, a_s1, a_s0}, {2'b0, m_s[0]});
      checkOutput("A.drop",  {3'b0, a_drop}, {3'b0, m_drop[0]});
      if (m_valid[0]) checkOutput("A.multi", {3'b0, a_multi}, {3'b0, m_multi[0]});
      checkOutput("B.valid", {3'b0, b_valid}, {3'b0, m_valid[1]});
      checkOutput("B.s",     {2'b0, b_s1, b_s0}, {2'b0, m_s[1]});
      checkOutput("B.drop",  {3'b0, b_drop}, {3'b0, m_drop[1]});
      if (m_valid[1]) checkOutput("B.multi", {3'b0, b_multi}, {3'b0, m_multi[1]});
    end
  end

  task automatic applyStimulus(input logic [3:0] lines, input logic rdy);
    {d3, d2, d1, d0} = lines;
    ready = rdy;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkA(input string name, input logic v, input logic [1:0] s, input logic mu);
    checkOutput({name, ".valid"}, {3'b0, a_valid}, {3'b0, v});
    if (v) begin
      checkOutput({name, ".s"}, {2'b0, a_s1, a_s0}, {2'b0, s});
      checkOutput({name, ".multi"}, {3'b0, a_multi}, {3'b0, mu});
    end
  endtask

  task automatic checkB(input string name, input logic v, input logic [1:0] s, input logic mu);
    checkOutput({name, ".valid"}, {3'b0, b_valid}, {3'b0, v});
    if (v) begin
      checkOutput({name, ".s"}, {2'b0, b_s1, b_s0}, {2'b0, s});
      checkOutput({name, ".multi"}, {3'b0, b_multi}, {3'b0, mu});
    end
  endtask

  task automatic settle();
    applyStimulus(4'hF, 1'b1);
    step(12);
  endtask

  initial begin
    applyStimulus(4'hF, 1'b0);
    step(3);
    #2 rst_n = 1'b1;

    // Reset and idle.
    for (int c = 0; c < 20; c++) begin
      step(1);
      checkOutput("idle.valid", {3'b0, a_valid}, 4'h0);
      checkOutput("idle.s", {2'b0, a_s1, a_s0}, 4'h0);
      checkOutput("idle.drop", {3'b0, a_drop}, 4'h0);
    end

    // Single event on d2, three edges of latency, no repeat while held low.
    applyStimulus(4'b1011, 1'b1);
    step(1); checkA("single.e1", 1'b0, 2'd0, 1'b0);
    step(1); checkA("single.e2", 1'b0, 2'd0, 1'b0);
    step(1); checkA("single.e3", 1'b0, 2'd0, 1'b0);
    step(1); checkA("single.e4", 1'b1, 2'd2, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1); checkA("single.held", 1'b0, 2'd0, 1'b0);
    end
    settle();

    // Burst d3,d1,d0 with five cycles of backpressure.
    applyStimulus(4'b0100, 1'b0);
    step(3); checkA("burst.pre", 1'b0, 2'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1); checkA("burst.hold", 1'b1, 2'd0, 1'b1);
    end
    applyStimulus(4'b0100, 1'b1);
    step(1); checkA("burst.second", 1'b1, 2'd1, 1'b1);
    step(1); checkA("burst.third", 1'b1, 2'd3, 1'b0);
    step(1); checkA("burst.done", 1'b0, 2'd0, 1'b0);
    settle();

    // Drop: three assertions on d1 while the first is held unaccepted.
    applyStimulus(4'b1101, 1'b0);
    step(4); checkA("drop.first", 1'b1, 2'd1, 1'b0);
    step(1);
    applyStimulus(4'hF, 1'b0);
    step(5);
    applyStimulus(4'b1101, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1); checkOutput("drop.second", {3'b0, a_drop}, 4'h0);
    end
    applyStimulus(4'hF, 1'b0);
    step(5);
    applyStimulus(4'b1101, 1'b0);
    step(2); checkOutput("drop.before", {3'b0, a_drop}, 4'h0);
    step(1); checkOutput("drop.pulse", {3'b0, a_drop}, 4'h1);
    step(1); checkOutput("drop.after", {3'b0, a_drop}, 4'h0);
    step(2); checkA("drop.stillheld", 1'b1, 2'd1, 1'b0);
    applyStimulus(4'b1101, 1'b1);
    step(1); checkA("drop.deliver2", 1'b1, 2'd1, 1'b0);
    step(1); checkA("drop.empty", 1'b0, 2'd0, 1'b0);
    step(3); checkA("drop.stayidle", 1'b0, 2'd0, 1'b0);
    settle();

    // High-first instance (3 stages): d0 and d3 together give 11 then 00.
    applyStimulus(4'b0110, 1'b1);
    step(4); checkB("hifirst.pre", 1'b0, 2'd0, 1'b0);
    step(1); checkB("hifirst.first", 1'b1, 2'd3, 1'b1);
    step(1); checkB("hifirst.second", 1'b1, 2'd0, 1'b0);
    step(1); checkB("hifirst.done", 1'b0, 2'd0, 1'b0);
    settle();

    // Reset mid-operation, d2 held low through release.
    applyStimulus(4'b1000, 1'b0);
    step(4); checkA("rst.loaded", 1'b1, 2'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.valid", {3'b0, a_valid}, 4'h0);
    checkOutput("rst.s", {2'b0, a_s1, a_s0}, 4'h0);
    checkOutput("rst.multi", {3'b0, a_multi}, 4'h0);
    checkOutput("rst.drop", {3'b0, a_drop}, 4'h0);
    checkOutput("rst.bvalid", {3'b0, b_valid}, 4'h0);
    applyStimulus(4'b1011, 1'b1);
    step(1);
    #2 rst_n = 1'b1;
    step(1); checkA("rst.e1", 1'b0, 2'd0, 1'b0);
    step(1); checkA("rst.e2", 1'b0, 2'd0, 1'b0);
    step(1); checkA("rst.e3", 1'b0, 2'd0, 1'b0);
    step(1); checkA("rst.e4", 1'b1, 2'd2, 1'b0);
    step(1); checkA("rst.e5", 1'b0, 2'd0, 1'b0);
    settle();

    // Randomised traffic with occasional resets, checked by the model.
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] lines;
      step(1);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        step(1);
        #2 rst_n = 1'b1;
      end else begin
        lines = {d3, d2, d1, d0};
        for (int i = 0; i < 4; i++) if ($urandom_range(0, 4) == 0) lines[i] = ~lines[i];
        applyStimulus(lines, $urandom_range(0, 3) != 0);
      end
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
